// File: rtl/scic_mem_arbiter.sv
// Shares one single-port synchronous RAM between the SCIC CPU port and the debug/loader port.
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP, and every output is registered.
module scic_mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
        $error("scic_mem_arbiter: MEM_LATENCY must be within 1..7");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;   // 1 = debug port
    logic                  last_q, last_d;     // owner of the previous issued access
    logic                  we_q, we_d;
    logic                  cpu_gnt_q, cpu_gnt_d;
    logic                  dbg_gnt_q, dbg_gnt_d;
    logic                  cpu_rvalid_q, cpu_rvalid_d;
    logic                  dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  win_dbg;

    // On a tie the port that did not own the previous access wins.
    assign win_dbg = dbg_req && (!cpu_req || !last_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_d       = last_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_d     = win_dbg;
                    we_d        = win_dbg ? dbg_we : cpu_we;
                    mem_addr_d  = win_dbg ? dbg_addr : cpu_addr;
                    mem_wdata_d = win_dbg ? dbg_wdata : cpu_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    cpu_gnt_d   = !win_dbg;
                    dbg_gnt_d   = win_dbg;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                last_d  = owner_q;
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    cpu_rvalid_d = !owner_q;
                    dbg_rvalid_d = owner_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            we_q         <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            rdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            we_q         <= we_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            rdata_q      <= rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dbg_gnt    = dbg_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign rdata      = rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scic_mem_arbiter.sv
// Bench for scic_mem_arbiter: three instances (MEM_LATENCY 1, 3, 4), each with a latency-accurate RAM
// and a transaction-level reference model checked every cycle, plus directed scenarios and random traffic.
module tb_scic_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int N  = 3;

    logic clock = 1'b0;
    logic reset;

    logic          cpu_req [N];
    logic          cpu_we [N];
    logic [AW-1:0] cpu_addr [N];
    logic [DW-1:0] cpu_wdata [N];
    logic          cpu_gnt [N];
    logic          cpu_rvalid [N];
    logic          dbg_req [N];
    logic          dbg_we [N];
    logic [AW-1:0] dbg_addr [N];
    logic [DW-1:0] dbg_wdata [N];
    logic          dbg_gnt [N];
    logic          dbg_rvalid [N];
    logic [DW-1:0] rdata [N];
    logic          mem_en [N];
    logic          mem_we [N];
    logic [AW-1:0] mem_addr [N];
    logic [DW-1:0] mem_wdata [N];
    logic [DW-1:0] mem_rdata [N];
    logic          busy [N];

    bit cpend [N];
    bit dpend [N];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, 8'hA5, ~a, 8'h3C};
    endfunction

    function automatic logic [6:0] ctrl_of(input int i);
        return {busy[i], cpu_gnt[i], dbg_gnt[i], cpu_rvalid[i], dbg_rvalid[i], mem_en[i], mem_we[i]};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;

        scic_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_gnt   (cpu_gnt[g]),
            .cpu_rvalid(cpu_rvalid[g]),
            .dbg_req   (dbg_req[g]),
            .dbg_we    (dbg_we[g]),
            .dbg_addr  (dbg_addr[g]),
            .dbg_wdata (dbg_wdata[g]),
            .dbg_gnt   (dbg_gnt[g]),
            .dbg_rvalid(dbg_rvalid[g]),
            .rdata     (rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );

        // RAM: read data appears L cycles after the enable is sampled; idle slots carry junk.
        logic [DW-1:0] env_mem [256];
        logic [DW-1:0] pipe [L];

        initial begin
            for (int a = 0; a < 256; a++) env_mem[a] <= init_val(8'(a));
        end

        always @(posedge clock) begin
            if (mem_en[g] && mem_we[g]) env_mem[mem_addr[g][7:0]] <= mem_wdata[g];
            pipe[0] <= (mem_en[g] && !mem_we[g]) ? env_mem[mem_addr[g][7:0]] : $urandom;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end

        assign mem_rdata[g] = pipe[L-1];

        // Reference: ph counts cycles since the winning request was sampled (0 = arbiter idle).
        int            ph = 0;
        bit            own = 1'b0;
        bit            mwe = 1'b0;
        bit            last_dbg = 1'b1;
        logic [AW-1:0] maddr = '0;
        logic [DW-1:0] mwd = '0;
        logic [DW-1:0] exp_rdata = '0;
        logic [DW-1:0] ref_mem [256];
        logic [6:0]    exp_ctrl;

        initial begin
            for (int a = 0; a < 256; a++) ref_mem[a] <= init_val(8'(a));
        end

        always @(posedge clock or negedge reset) begin
            if (!reset) begin
                ph        <= 0;
                last_dbg  <= 1'b1;
                exp_rdata <= '0;
            end else if (ph == 0) begin
                if (cpu_req[g] || dbg_req[g]) begin
                    own   <= (cpu_req[g] && dbg_req[g]) ? !last_dbg : dbg_req[g];
                    mwe   <= (cpu_req[g] && dbg_req[g]) ? (last_dbg ? cpu_we[g] : dbg_we[g])
                                                        : (dbg_req[g] ? dbg_we[g] : cpu_we[g]);
                    maddr <= (cpu_req[g] && dbg_req[g]) ? (last_dbg ? cpu_addr[g] : dbg_addr[g])
                                                        : (dbg_req[g] ? dbg_addr[g] : cpu_addr[g]);
                    mwd   <= (cpu_req[g] && dbg_req[g]) ? (last_dbg ? cpu_wdata[g] : dbg_wdata[g])
                                                        : (dbg_req[g] ? dbg_wdata[g] : cpu_wdata[g]);
                    ph    <= 1;
                end
            end else begin
                if (ph == 1) begin
                    last_dbg <= own;
                    if (mwe) ref_mem[maddr[7:0]] <= mwd;
                end
                if (ph == L + 1 && !mwe) exp_rdata <= ref_mem[maddr[7:0]];
                ph <= (ph == L + 2) ? 0 : ph + 1;
            end
        end

        assign exp_ctrl = {ph != 0, ph == 1 && !own, ph == 1 && own, ph == L + 2 && !own,
                           ph == L + 2 && own, ph == 1, ph == 1 && mwe};

        always @(negedge clock) begin
            check($sformatf("L%0d ctrl", L), 64'(ctrl_of(g)), 64'(exp_ctrl));
            check($sformatf("L%0d rdata", L), 64'(rdata[g]), 64'(exp_rdata));
            if (ph == 1) begin
                check($sformatf("L%0d mem_addr", L), 64'(mem_addr[g]), 64'(maddr));
                check($sformatf("L%0d mem_wdata", L), 64'(mem_wdata[g]), 64'(mwd));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int port_act(input logic req, input logic gnt, input bit pend);
        if (pend) return 1;
        if (req && gnt) return 3;
        if (req && $urandom_range(0, 15) == 0) return 1;
        if (!req && $urandom_range(0, 2) == 0) return 2;
        return 0;
    endfunction

    int         gq[$];
    int         gc[$];
    logic [3:0] ord;

    initial begin
        for (int i = 0; i < N; i++) begin
            cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            dbg_req[i] = 1'b0; dbg_we[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
            cpend[i] = 1'b0; dpend[i] = 1'b0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        check("reset ctrl", 64'(ctrl_of(0)), 64'(0));
        check("reset rdata", 64'(rdata[0]), 64'(0));
        check("reset mem_addr", 64'(mem_addr[0]), 64'(0));
        #1 reset = 1'b1;
        tick();

        // CPU read of 0x0010, latency 1
        cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0010; cpu_req[0] = 1'b1;
        tick();
        check("rd cpu_gnt", 64'(cpu_gnt[0]), 64'(1));
        check("rd mem_en", 64'(mem_en[0]), 64'(1));
        check("rd mem_addr", 64'(mem_addr[0]), 64'h0010);
        check("rd mem_we", 64'(mem_we[0]), 64'(0));
        check("rd busy+1", 64'(busy[0]), 64'(1));
        cpu_req[0] = 1'b0;
        tick();
        check("rd busy+2", 64'(busy[0]), 64'(1));
        check("rd early rvalid", 64'(cpu_rvalid[0]), 64'(0));
        tick();
        check("rd cpu_rvalid", 64'(cpu_rvalid[0]), 64'(1));
        check("rd rdata", 64'(rdata[0]), 64'hDEADBEEF);
        check("rd busy+3", 64'(busy[0]), 64'(1));
        tick();
        check("rd busy+4", 64'(busy[0]), 64'(0));

        // Debug write of 0x12345678 to 0x0004
        dbg_we[0] = 1'b1; dbg_addr[0] = 16'h0004; dbg_wdata[0] = 32'h12345678; dbg_req[0] = 1'b1;
        tick();
        check("wr dbg_gnt", 64'(dbg_gnt[0]), 64'(1));
        check("wr mem_we", 64'(mem_we[0]), 64'(1));
        check("wr mem_wdata", 64'(mem_wdata[0]), 64'h12345678);
        check("wr mem_addr", 64'(mem_addr[0]), 64'h0004);
        check("wr cpu quiet+1", 64'({cpu_gnt[0], cpu_rvalid[0]}), 64'(0));
        dbg_req[0] = 1'b0;
        tick();
        tick();
        check("wr dbg_rvalid", 64'(dbg_rvalid[0]), 64'(1));
        check("wr cpu quiet+3", 64'({cpu_gnt[0], cpu_rvalid[0]}), 64'(0));
        check("wr rdata kept", 64'(rdata[0]), 64'hDEADBEEF);
        tick();

        // Debug request pulsed only while the CPU access is in flight
        cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0020; cpu_req[0] = 1'b1;
        tick();
        check("pulse cpu_gnt", 64'(cpu_gnt[0]), 64'(1));
        cpu_req[0] = 1'b0;
        dbg_we[0] = 1'b0; dbg_addr[0] = 16'h0024; dbg_req[0] = 1'b1;
        tick();
        dbg_req[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("pulse no dbg_gnt", 64'(dbg_gnt[0]), 64'(0));
            check("pulse no mem_en", 64'(mem_en[0]), 64'(0));
        end

        // Both ports held from reset release: CPU first, then strict alternation
        reset = 1'b0;
        cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0030; cpu_req[0] = 1'b1;
        dbg_we[0] = 1'b0; dbg_addr[0] = 16'h0040; dbg_req[0] = 1'b1;
        tick();
        #2 reset = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("alt single gnt", 64'(cpu_gnt[0] && dbg_gnt[0]), 64'(0));
            if (cpu_gnt[0]) begin gq.push_back(0); gc.push_back(c); end
            if (dbg_gnt[0]) begin gq.push_back(1); gc.push_back(c); end
        end
        cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
        check("alt gnt count", 64'(gq.size()), 64'(4));
        ord = '0;
        for (int k = 0; k < gq.size() && k < 4; k++) ord[k] = gq[k][0];
        check("alt order", 64'(ord), 64'(4'b1010));
        if (gc.size() > 0) check("alt first gnt cycle", 64'(gc[0]), 64'(1));
        for (int k = 1; k < gc.size(); k++) check("alt gnt spacing", 64'(gc[k] - gc[k-1]), 64'(4));
        repeat (6) tick();

        // Reset during WAIT with latency 3
        cpu_we[1] = 1'b0; cpu_addr[1] = 16'h0050; cpu_req[1] = 1'b1;
        tick();
        check("rst cpu_gnt", 64'(cpu_gnt[1]), 64'(1));
        cpu_req[1] = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        check("rst outs clear", 64'(ctrl_of(1)), 64'(0));
        check("rst rdata clear", 64'(rdata[1]), 64'(0));
        tick();
        #2 reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rst no rvalid", 64'({cpu_rvalid[1], dbg_rvalid[1]}), 64'(0));
        end
        cpu_req[1] = 1'b1;
        dbg_we[1] = 1'b0; dbg_addr[1] = 16'h0058; dbg_req[1] = 1'b1;
        tick();
        check("rst cpu first", 64'({cpu_gnt[1], dbg_gnt[1]}), 64'(2'b10));
        cpu_req[1] = 1'b0; dbg_req[1] = 1'b0;
        repeat (7) tick();

        // CPU read with latency 4
        cpu_we[2] = 1'b0; cpu_addr[2] = 16'h0060; cpu_req[2] = 1'b1;
        tick();
        check("l4 cpu_gnt", 64'(cpu_gnt[2]), 64'(1));
        cpu_req[2] = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("l4 early rvalid", 64'(cpu_rvalid[2]), 64'(0));
        end
        check("l4 rdata before", 64'(rdata[2]), 64'(0));
        tick();
        check("l4 cpu_rvalid", 64'(cpu_rvalid[2]), 64'(1));
        check("l4 rdata", 64'(rdata[2]), 64'(init_val(8'h60)));
        tick();
        check("l4 idle", 64'(busy[2]), 64'(0));

        // Random traffic on all instances
        for (int n = 0; n < 1500; n++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                case (port_act(cpu_req[i], cpu_gnt[i], cpend[i]))
                    1: begin cpu_req[i] = 1'b0; cpend[i] = 1'b0; end
                    2: begin
                        cpu_req[i] = 1'b1; cpu_we[i] = 1'($urandom);
                        cpu_addr[i] = 16'($urandom); cpu_wdata[i] = $urandom;
                    end
                    3: cpend[i] = 1'b1;
                    default: ;
                endcase
                case (port_act(dbg_req[i], dbg_gnt[i], dpend[i]))
                    1: begin dbg_req[i] = 1'b0; dpend[i] = 1'b0; end
                    2: begin
                        dbg_req[i] = 1'b1; dbg_we[i] = 1'($urandom);
                        dbg_addr[i] = 16'($urandom); dbg_wdata[i] = $urandom;
                    end
                    3: dpend[i] = 1'b1;
                    default: ;
                endcase
            end
        end
        for (int i = 0; i < N; i++) begin
            cpu_req[i] = 1'b0;
            dbg_req[i] = 1'b0;
        end
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
